// File: rtl/seq_csel_sub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : seq_csel_sub                                                   |
// | Brief   : 8-bit sequential subtractor, two 4-bit carry-select slices     |
// |           computing a + ~b + ~bin; signed overflow under CSEL_SUB_OVF_EN |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seq_csel_sub (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bin,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] diff,
  output logic       bout
`ifdef CSEL_SUB_OVF_EN
  ,
  output logic       ovf
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_run;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_bin;
  logic       r_c_lo;
  logic [7:0] r_diff;
  logic       r_bout;
  logic       w_accept;
  logic [4:0] w_lo0;
  logic [4:0] w_lo1;
  logic [4:0] w_lo;
  logic [4:0] w_hi0;
  logic [4:0] w_hi1;
  logic [4:0] w_hi;

  // Both carry-in variants of each slice; the select picks one.
  assign w_lo0 = {1'b0, r_a[3:0]} + {1'b0, ~r_b[3:0]};
  assign w_lo1 = {1'b0, r_a[3:0]} + {1'b0, ~r_b[3:0]} + 5'd1;
  assign w_lo  = r_bin ? w_lo0 : w_lo1;
  assign w_hi0 = {1'b0, r_a[7:4]} + {1'b0, ~r_b[7:4]};
  assign w_hi1 = {1'b0, r_a[7:4]} + {1'b0, ~r_b[7:4]} + 5'd1;
  assign w_hi  = r_c_lo ? w_hi1 : w_hi0;

  assign w_accept = in_ready && in_valid;

  // in_ready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_LO;
      S_LO:    w_state_nxt = S_HI;
      S_HI:    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = r_run && (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= 8'h00;
      r_b    <= 8'h00;
      r_bin  <= 1'b0;
      r_c_lo <= 1'b0;
      r_diff <= 8'h00;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_bin <= bin;
    end else if (r_state == S_LO) begin
      r_diff[3:0] <= w_lo[3:0];
      r_c_lo      <= w_lo[4];
    end else if (r_state == S_HI) begin
      r_diff[7:4] <= w_hi[3:0];
      r_bout      <= ~w_hi[4];
    end
  end

`ifdef CSEL_SUB_OVF_EN
  logic r_ovf;

  // Uses the freshly computed sign bit of the high slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_HI) begin
      r_ovf <= (r_a[7] != r_b[7]) && (w_hi[3] != r_a[7]);
    end
  end

  assign ovf = r_ovf;
`endif

  assign diff = r_diff;
  assign bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_seq_csel_sub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_seq_csel_sub                                                |
// | Brief   : randomized self-checking bench for seq_csel_sub                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_seq_csel_sub;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;
`ifdef CSEL_SUB_OVF_EN
  logic       ovf;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int n_ops   = 0;
  int n_hs    = 0;

  seq_csel_sub dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout)
`ifdef CSEL_SUB_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) n_hs <= n_hs + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for in_ready at a falling edge.
  task automatic wait_ready();
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  // One full transaction; expected values come from plain integer arithmetic.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                       input int hold, input bit pulse, input bit rrdy);
    int         ia, ib, ic, idiff;
    logic [7:0] ed;
    logic       eb;
    logic       eo;
    ia    = ta;
    ib    = tb;
    ic    = tbin;
    idiff = ia - ib - ic;
    ed    = idiff[7:0];
    eb    = (ia < ib + ic);
    eo    = (ta[7] != tb[7]) && (ed[7] != ta[7]);

    wait_ready();
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    out_ready = rrdy ? 1'($urandom) : 1'b0;
    @(negedge clk);
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    in_valid  = rrdy ? 1'($urandom) : 1'b0;
    out_ready = rrdy ? 1'($urandom) : 1'b0;
    chk("lo_out_valid", {31'd0, out_valid}, 32'd0);
    chk("lo_in_ready",  {31'd0, in_ready},  32'd0);
    @(negedge clk);
    in_valid  = rrdy ? 1'($urandom) : 1'b0;
    out_ready = rrdy ? 1'($urandom) : 1'b0;
    chk("hi_out_valid", {31'd0, out_valid}, 32'd0);
    chk("hi_in_ready",  {31'd0, in_ready},  32'd0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("done_out_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      chk("hold_diff",     {24'd0, diff},     {24'd0, ed});
      chk("hold_bout",     {31'd0, bout},     {31'd0, eb});
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = pulse && (i == 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    chk("diff", {24'd0, diff}, {24'd0, ed});
    chk("bout", {31'd0, bout}, {31'd0, eb});
`ifdef CSEL_SUB_OVF_EN
    chk("ovf", {31'd0, ovf}, {31'd0, eo});
`else
    if (eo === 1'bx) $display("note: unexpected x in ovf model");
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_ops++;
    chk("post_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_in_ready",  {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h00; b = 8'h00; bin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_diff",      {24'd0, diff},      32'd0);
    chk("rst_bout",      {31'd0, bout},      32'd0);
`ifdef CSEL_SUB_OVF_EN
    chk("rst_ovf",       {31'd0, ovf},       32'd0);
`endif
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("rel_in_ready_high", {31'd0, in_ready}, 32'd1);

    // Directed cases: basic, cross-slice borrow, wrap, signed overflow.
    do_op(8'h53, 8'h21, 1'b0, 0, 1'b0, 1'b0);
    do_op(8'h10, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    do_op(8'h00, 8'h00, 1'b1, 0, 1'b0, 1'b0);
    do_op(8'h80, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0, 1'b0);
    do_op(8'h7F, 8'h80, 1'b0, 0, 1'b0, 1'b0);
    // Consumer stall with an ignored in_valid pulse.
    do_op(8'hA5, 8'h3C, 1'b1, 3, 1'b1, 1'b0);

    // Reset while the high slice is pending.
    wait_ready();
    a = 8'hFF; b = 8'h01; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_diff",      {24'd0, diff},      32'd0);
    chk("abort_bout",      {31'd0, bout},      32'd0);
    chk("abort_in_ready",  {31'd0, in_ready},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_result", {31'd0, out_valid}, 32'd0);
    end
    do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), 1'($urandom), 1'b1);
    end

    @(negedge clk);
    chk("handshake_count", n_hs, n_ops);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_csel_sub.md
SEQ_CSEL_SUB -- requirements
Module: seq_csel_sub

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 8 bits, processed as two 4-bit carry-select slices.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operand bundle valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  8  minuend, unsigned/two's complement.
REQ-007 b  input  8  subtrahend.
REQ-008 bin  input  1  borrow in.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 diff  output  8  registered result, (a - b - bin) mod 256.
REQ-012 bout  output  1  borrow out, 1 when a < b + bin (unsigned).
REQ-013 ovf  output  1  signed overflow; present only under CSEL_SUB_OVF_EN.

Function
REQ-014 The FSM SHALL have the states IDLE, LO, HI and DONE.
REQ-015 IDLE: in_ready=1; on in_valid=1, latch a, b and bin, then go to LO.
REQ-016 LO, HI and DONE: in_ready=0; in_valid SHALL be ignored.
REQ-017 Subtraction SHALL be computed as a + ~b + ~bin.
REQ-018 LO: compute the low slice for both carry-in 0 and carry-in 1, select with ~bin, register diff[3:0] and the slice carry, then go to HI.
REQ-019 HI: compute the high slice for both carry-ins, select with the registered low carry, register diff[7:4], set bout = ~carry_out, then go to DONE.
REQ-020 DONE: out_valid=1; diff, bout and ovf SHALL be held stable until out_valid && out_ready.
REQ-021 On acceptance in DONE, the block SHALL go to IDLE and clear out_valid on the same edge; in_ready=1 in the following cycle.
REQ-022 Latency: acceptance at edge E0 -> out_valid high after edge E2; minimum initiation interval 4 cycles.
REQ-023 If out_ready is high on the first DONE cycle, the block SHALL accept and return to IDLE at edge E3.
REQ-024 out_ready asserted outside DONE SHALL have no effect.
REQ-025 Borrow SHALL propagate across the slice boundary, e.g. 8'h10 - 8'h01 = 8'h0F.
REQ-026 diff SHALL wrap modulo 256, with no saturation.
REQ-027 diff and bout SHALL keep their last values in IDLE, LO and HI, and SHALL be meaningful only while out_valid=1.

Reset
REQ-028 While rst_n=0, the block SHALL set state=IDLE, in_ready=0, out_valid=0, diff=8'h00, bout=0, ovf=0 and operand registers=0.
REQ-029 in_ready SHALL rise in the first cycle after rst_n is deasserted.
REQ-030 Reset asserted in LO, HI or DONE SHALL abort the operation immediately; no partial result SHALL appear after release.

Configuration
REQ-031 The macro CSEL_SUB_OVF_EN SHALL control the overflow feature.
REQ-032 With CSEL_SUB_OVF_EN defined, the ovf port SHALL exist and SHALL be registered in HI as (a[7] != b[7]) && (diff[7] != a[7]).
REQ-033 ovf SHALL be held with diff, cleared by reset, and excluded from borrow logic.
REQ-034 Without CSEL_SUB_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-035 a=8'h53, b=8'h21, bin=0, out_ready=1 -> out_valid after E2, diff=8'h32, bout=0, ovf=0.
REQ-036 a=8'h10, b=8'h01, bin=0 -> diff=8'h0F, bout=0; then a=8'h00, b=8'h00, bin=1 -> diff=8'hFF, bout=1.
REQ-037 a=8'h80, b=8'h01, bin=0 with CSEL_SUB_OVF_EN defined -> diff=8'h7F, bout=0, ovf=1; same stimulus without the macro -> diff=8'h7F, no ovf port.
REQ-038 out_ready low for 3 cycles in DONE with in_valid pulsed meanwhile -> diff/bout stable, in_ready=0, pulse dropped; out_ready high -> IDLE next edge.
REQ-039 rst_n pulsed low during HI for a=8'hFF, b=8'h01 -> out_valid=0, diff=8'h00 immediately; no result after release; next transaction correct.
REQ-040 Random back-to-back run, 1000 operands with random out_ready -> every diff/bout matches the a-b-bin model, no lost or duplicated results.
